// File: rtl/sw_debounce_pkg.sv
// Board-level constants shared by the switch debouncer and the switch-to-address encoder.
package board_pkg;

    localparam int unsigned SW_WIDTH         = 16;
    localparam int unsigned BOARD_CLK_HZ     = 100_000_000;
    localparam int unsigned DEBOUNCE_HZ      = 1_000;
    localparam int unsigned DEBOUNCE_SAMPLES = 4;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit debouncer: flips its output after STABLE_SAMPLES consecutive
// disagreeing sample ticks; any agreeing tick restarts the count.
module debounce_bit
    import board_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEBOUNCE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din_sync,
    output logic dout,
    output logic flip
);

    localparam int unsigned        CNT_W    = cnt_width(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // Count disagreeing ticks; the count only moves in tick cycles.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        flip   = 1'b0;
        if (tick) begin
            if (din_sync == dout_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                dout_d = ~dout_q;
                cnt_d  = '0;
                flip   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and debounced value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchroniser per bit, shared sample-tick prescaler,
// one debounce_bit per switch and a single change strobe for the whole vector.
module sw_debounce
    import board_pkg::*;
#(
    parameter int unsigned WIDTH          = SW_WIDTH,
    parameter int unsigned CLK_HZ         = BOARD_CLK_HZ,
    parameter int unsigned SAMPLE_HZ      = DEBOUNCE_HZ,
    parameter int unsigned STABLE_SAMPLES = DEBOUNCE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             sw_changed,
    output logic             sample_tick
);

    localparam int unsigned      DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned      PRE_W    = cnt_width(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("sw_debounce: CLK_HZ/SAMPLE_HZ must be at least 2");
    end
    if (STABLE_SAMPLES < 1) begin : g_bad_samples
        $error("sw_debounce: STABLE_SAMPLES must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sw_debounce: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] flip_vec;

    // Prescaler wrap and tick look-ahead so the registered tick lines up with pre_q == DIV-1.
    always_comb begin
        pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        tick_d    = (pre_d == PRE_LAST);
        changed_d = |flip_vec;
    end

    // Synchroniser, prescaler, tick and change-strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            changed_q <= changed_d;
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        debounce_bit #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick_q),
            .din_sync(sync2_q[i]),
            .dout    (sw_clean[i]),
            .flip    (flip_vec[i])
        );
    end

    assign sample_tick = tick_q;
    assign sw_changed  = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a cycle-level reference model feeding a scoreboard.
module tb_sw_debounce;

    localparam int unsigned W   = 16;
    localparam int unsigned DIV = 10;
    localparam int unsigned SS  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic         sw_changed;
    logic         sample_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;

    logic [W+1:0] sb[$];
    logic [W+1:0] exp_v;

    sw_debounce #(
        .WIDTH         (W),
        .CLK_HZ        (100),
        .SAMPLE_HZ     (10),
        .STABLE_SAMPLES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_clean, m_nclean;
    logic         m_tick, m_chg, m_fl;
    int           m_pre;
    int           m_cnt[W];

    // Reference model: pushes the expected post-edge outputs at every rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0;
            m_tick = 1'b0; m_chg = 1'b0; m_pre = 0;
            for (int i = 0; i < int'(W); i++) m_cnt[i] = 0;
            sb.delete();
        end else begin
            m_nclean = m_clean;
            m_fl = 1'b0;
            if (m_tick) begin
                for (int i = 0; i < int'(W); i++) begin
                    if (m_s2[i] == m_clean[i]) begin
                        m_cnt[i] = 0;
                    end else if (m_cnt[i] == int'(SS) - 1) begin
                        m_nclean[i] = ~m_clean[i];
                        m_cnt[i] = 0;
                        m_fl = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
            m_pre = (m_pre + 1) % int'(DIV);
            m_tick = (m_pre == int'(DIV) - 1);
            m_clean = m_nclean;
            m_chg = m_fl;
            sb.push_back({m_clean, m_chg, m_tick});
        end
    end

    // Scoreboard compare on the falling edge, plus change-pulse counting.
    always @(negedge clk) begin
        if (sw_changed === 1'b1) n_pulse++;
        if (rst_n === 1'b1 && sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_checks++;
            assert ({sw_clean, sw_changed, sample_tick} === exp_v) else begin
                n_fail++;
                $error("FAIL sb_cycle got %h expected %h at %0t",
                       {sw_clean, sw_changed, sample_tick}, exp_v, $time);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for a change strobe, giving up after max_cyc edges; returns the edge count.
    task automatic wait_chg(input int max_cyc, input string tag, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            #1;
            if (sw_changed === 1'b1) begin
                cyc = k;
                break;
            end
        end
        check(tag, 32'(cyc > 0), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int p0;
        int c;
        int t;

        // 1. Power-up with all switches high
        sw_raw = '1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clean", 32'(sw_clean), 32'h0);
        check("rst_changed", 32'(sw_changed), 32'h0);
        check("rst_tick", 32'(sample_tick), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_pulse;
        settle(9);
        check("tick_first", 32'(sample_tick), 32'h1);
        settle(1);
        check("tick_after", 32'(sample_tick), 32'h0);
        settle(29);
        check("pu_before", 32'(sw_clean), 32'h0);
        settle(1);
        check("pu_clean", 32'(sw_clean), 32'hFFFF);
        check("pu_changed", 32'(sw_changed), 32'h1);
        settle(1);
        check("pu_changed_low", 32'(sw_changed), 32'h0);
        check("pu_pulses", 32'(n_pulse - p0), 32'd1);

        // Release everything to reach all-zero
        p0 = n_pulse;
        sw_raw = '0;
        wait_chg(45, "rel_all_seen", c);
        check("rel_all_latency", 32'(c >= 33 && c <= 42), 32'd1);
        check("rel_all_clean", 32'(sw_clean), 32'h0);
        settle(15);
        check("rel_all_pulses", 32'(n_pulse - p0), 32'd1);

        // 2. Glitch on bit 3 shorter than four ticks
        p0 = n_pulse;
        sw_raw = 16'h0008;
        settle(25);
        sw_raw = 16'h0000;
        settle(60);
        check("glitch_clean", 32'(sw_clean), 32'h0);
        check("glitch_pulses", 32'(n_pulse - p0), 32'd0);

        // 3. Bits 5 and 12 rise together
        p0 = n_pulse;
        sw_raw = 16'h1020;
        wait_chg(45, "simul_seen", c);
        check("simul_clean", 32'(sw_clean), 32'h1020);
        check("simul_latency", 32'(c >= 33 && c <= 42), 32'd1);
        settle(15);
        check("simul_pulses", 32'(n_pulse - p0), 32'd1);

        // 4. Bit 0 bounces every 7 cycles, then settles high
        p0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            sw_raw = 16'h1020 | ((i % 2 == 0) ? 16'h0001 : 16'h0000);
            settle(7);
        end
        check("bounce_hold", 32'(sw_clean), 32'h1020);
        check("bounce_no_pulse", 32'(n_pulse - p0), 32'd0);
        sw_raw = 16'h1021;
        wait_chg(45, "bounce_seen", c);
        check("bounce_clean", 32'(sw_clean), 32'h1021);
        settle(15);
        check("bounce_pulses", 32'(n_pulse - p0), 32'd1);

        // 5. Asynchronous reset after bit 7 has disagreed for three ticks
        sw_raw = 16'h10A1;
        settle(2);
        t = 0;
        for (int k = 0; k < 40 && t < 3; k++) begin
            settle(1);
            if (sample_tick === 1'b1) t++;
        end
        check("b7_ticks", 32'(t), 32'd3);
        @(posedge clk);
        #2;
        check("b7_not_yet", 32'(sw_clean), 32'h1021);
        rst_n = 1'b0;
        #1;
        check("arst_clean", 32'(sw_clean), 32'h0);
        check("arst_changed", 32'(sw_changed), 32'h0);
        check("arst_tick", 32'(sample_tick), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_pulse;
        settle(39);
        check("arst_fresh_before", 32'(sw_clean), 32'h0);
        settle(1);
        check("arst_fresh_clean", 32'(sw_clean), 32'h10A1);
        check("arst_fresh_changed", 32'(sw_changed), 32'h1);
        settle(5);
        check("arst_pulses", 32'(n_pulse - p0), 32'd1);

        // 6. Back to 0x1020, then release all switches
        sw_raw = 16'h1020;
        settle(60);
        check("pre_rel_clean", 32'(sw_clean), 32'h1020);
        p0 = n_pulse;
        sw_raw = 16'h0000;
        wait_chg(45, "rel_seen", c);
        check("rel_clean", 32'(sw_clean), 32'h0);
        check("rel_latency", 32'(c >= 33 && c <= 42), 32'd1);
        settle(15);
        check("rel_pulses", 32'(n_pulse - p0), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
